// File: rtl/exc_ctrl.sv
// exc_ctrl: precise exception/interrupt controller with Status/Cause/EPC, flush and PC redirect
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0008,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_ov,
  input  logic [31:0] ex_pc,
  input  logic        id_valid,
  input  logic        id_syscall,
  input  logic        id_eret,
  input  logic [31:0] id_pc,
  input  logic        intr,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        intr_ack
);
  typedef enum logic {RUN, SETTLE} state_t;
  state_t state_q, state_d;
  logic [1:0] status_q, status_d;
  logic [4:0] code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d, pend_q, pend_d;
  logic run, take_ov, take_sys, do_eret, take_int, take, mtc0_status;
  logic unused_ok;
  assign unused_ok = ^cp0_wdata[31:2];
  always_comb begin
    run = (state_q == RUN) && !rst;
    take_ov = run & ex_valid & ex_ov;
    take_sys = run & ~take_ov & id_valid & id_syscall;
    do_eret = run & ~take_ov & ~take_sys & id_valid & id_eret;
    take_int = run & ~take_ov & ~take_sys & ~id_eret & id_valid & pend_q & status_q[0] & ~status_q[1];
    take = take_ov | take_sys | take_int;
    flush = take | do_eret;
    pc_redirect = flush;
    redirect_pc = take ? HANDLER_ADDR : do_eret ? epc_q : 32'h0;
    intr_ack = take_int;
    sync_d = {sync_q[SYNC_STAGES-2:0], intr};
    prev_d = sync_q[SYNC_STAGES-1];
    pend_d = (pend_q & ~take_int) | (sync_q[SYNC_STAGES-1] & ~prev_q);
    mtc0_status = cp0_we & ex_valid & (cp0_addr == 5'd12);
    // a same-cycle mtc0 lands first; exception entry/return then owns EXL
    status_d[0] = mtc0_status ? cp0_wdata[0] : status_q[0];
    status_d[1] = take | (~do_eret & (mtc0_status ? cp0_wdata[1] : status_q[1]));
    code_d = take_ov ? 5'd12 : take_sys ? 5'd8 : take_int ? 5'd0 : code_q;
    // nested exceptions keep the original return address
    epc_d = (take & ~status_q[1]) ? (take_ov ? ex_pc : id_pc) : epc_q;
    state_d = flush ? SETTLE : RUN;
    cp0_rdata = (cp0_addr == 5'd12) ? {30'h0, status_q} :
                (cp0_addr == 5'd13) ? {21'h0, pend_q, 3'h0, code_q, 2'h0} :
                (cp0_addr == 5'd14) ? epc_q : 32'h0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      status_q <= '0;
      code_q <= '0;
      epc_q <= '0;
      sync_q <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      code_q <= code_d;
      epc_q <= epc_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed stimulus with a behavioural reference model checked every cycle
module tb_exc_ctrl;
  localparam int S = 2;
  logic clk = 0;
  logic rst = 1;
  logic ex_valid, ex_ov, id_valid, id_syscall, id_eret, intr, cp0_we;
  logic [31:0] ex_pc, id_pc, cp0_wdata, cp0_rdata, redirect_pc;
  logic [4:0] cp0_addr;
  logic flush, pc_redirect, intr_ack;
  int checks = 0;
  int failures = 0;
  bit m_ie = 0, m_exl = 0, m_pend = 0, m_prev = 0, m_settle = 0;
  int m_code = 0;
  logic [31:0] m_epc = 0;
  bit sh [S];
  int u_a;
  bit u_oe, u_rise, got;
  exc_ctrl #(.HANDLER_ADDR(32'h8), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ov(ex_ov), .ex_pc(ex_pc),
    .id_valid(id_valid), .id_syscall(id_syscall), .id_eret(id_eret), .id_pc(id_pc),
    .intr(intr), .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .cp0_rdata(cp0_rdata), .flush(flush), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .intr_ack(intr_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got_v, exp_v, $time);
    end
  endtask
  // 0 none, 1 overflow, 2 syscall, 3 eret, 4 interrupt
  function automatic int act();
    if (rst || m_settle) return 0;
    if (ex_valid && ex_ov) return 1;
    if (id_valid && id_syscall) return 2;
    if (id_valid && id_eret) return 3;
    if (m_pend && m_ie && !m_exl && id_valid) return 4;
    return 0;
  endfunction
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (rst) return 0;
    if (a == 12) return {30'h0, m_exl, m_ie};
    if (a == 13) return (32'(m_pend) << 10) | (32'(m_code) << 2);
    if (a == 14) return m_epc;
    return 0;
  endfunction
  always @(negedge clk) begin
    chk("flush", {31'h0, flush}, {31'h0, act() != 0});
    chk("pc_redirect", {31'h0, pc_redirect}, {31'h0, act() != 0});
    chk("redirect_pc", redirect_pc, act() == 3 ? m_epc : act() != 0 ? 32'h8 : 32'h0);
    chk("intr_ack", {31'h0, intr_ack}, {31'h0, act() == 4});
    chk("cp0_rdata", cp0_rdata, m_rd(cp0_addr));
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ie = 0; m_exl = 0; m_code = 0; m_epc = 0; m_pend = 0; m_prev = 0; m_settle = 0;
      for (int i = 0; i < S; i++) sh[i] = 0;
    end else begin
      u_a = act();
      u_oe = m_exl;
      if (cp0_we && ex_valid && cp0_addr == 12) begin
        m_ie = cp0_wdata[0];
        m_exl = cp0_wdata[1];
      end
      if (u_a == 1 || u_a == 2 || u_a == 4) begin
        m_code = u_a == 1 ? 12 : u_a == 2 ? 8 : 0;
        if (!u_oe) m_epc = u_a == 1 ? ex_pc : id_pc;
        m_exl = 1;
      end
      if (u_a == 3) m_exl = 0;
      u_rise = sh[S-1] && !m_prev;
      m_pend = (m_pend && u_a != 4) || u_rise;
      m_prev = sh[S-1];
      for (int i = S - 1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = intr;
      m_settle = u_a != 0;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ex_valid = 0; ex_ov = 0; ex_pc = 0; id_valid = 0; id_syscall = 0; id_eret = 0;
    id_pc = 0; cp0_we = 0; cp0_addr = 0; cp0_wdata = 0;
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
    cp0_addr = a;
    #1;
    chk(n, cp0_rdata, e);
  endtask
  initial begin
    idle();
    intr = 0;
    step(); step();
    rst = 0;
    rd(12, 0, "rst_status"); rd(13, 0, "rst_cause"); rd(14, 0, "rst_epc");
    ex_valid = 1; ex_ov = 1; ex_pc = 32'h20; #1;
    chk("ov_flush", {31'h0, flush}, 1); chk("ov_redir", redirect_pc, 32'h8);
    step(); idle();
    rd(14, 32'h20, "ov_epc"); rd(13, 32'h30, "ov_cause"); rd(12, 2, "ov_status");
    step();
    id_valid = 1; id_eret = 1; id_pc = 32'h100; #1;
    chk("eret_redir", redirect_pc, 32'h20);
    step(); idle(); rd(12, 0, "eret_status"); step();
    ex_valid = 1; ex_ov = 1; ex_pc = 32'h40; id_valid = 1; id_syscall = 1; id_pc = 32'h44;
    step(); idle(); rd(14, 32'h40, "prio_epc"); rd(13, 32'h30, "prio_cause"); step();
    id_valid = 1; id_eret = 1; step(); idle(); step();
    ex_ov = 1; #1; chk("ov_novalid", {31'h0, flush}, 0); step(); idle();
    id_valid = 1; id_syscall = 1; id_pc = 32'h50;
    step(); idle(); rd(14, 32'h50, "sys_epc"); rd(13, 32'h20, "sys_cause"); step();
    ex_valid = 1; ex_ov = 1; ex_pc = 32'h60; #1; chk("nest_flush", {31'h0, flush}, 1);
    step(); idle(); rd(14, 32'h50, "nest_epc"); rd(13, 32'h30, "nest_cause"); step();
    id_valid = 1; id_eret = 1; #1; chk("nest_eret", redirect_pc, 32'h50);
    step(); idle(); step();
    intr = 1; id_valid = 1; id_pc = 32'h70;
    repeat (5) step();
    rd(13, 32'h430, "int_masked_ip");
    cp0_we = 1; ex_valid = 1; cp0_addr = 12; cp0_wdata = 1;
    step();
    cp0_we = 0; ex_valid = 0; #1;
    chk("int_ack", {31'h0, intr_ack}, 1); chk("int_redir", redirect_pc, 32'h8);
    step(); idle();
    rd(14, 32'h70, "int_epc"); rd(13, 0, "int_cause"); rd(12, 3, "int_status");
    step();
    id_valid = 1; id_eret = 1; step(); idle(); intr = 0;
    repeat (4) step();
    intr = 1; id_valid = 1; id_pc = 32'h80; got = 0;
    for (int i = 0; i < S + 2; i++) begin
      @(negedge clk);
      if (intr_ack) begin got = 1; break; end
    end
    chk("int_latency", {31'h0, got}, 1);
    step(); idle(); rd(14, 32'h80, "int2_epc"); step();
    id_valid = 1; id_eret = 1; step(); idle(); step();
    cp0_we = 1; ex_valid = 1; ex_ov = 1; ex_pc = 32'h90; cp0_addr = 12; cp0_wdata = 0;
    step(); idle();
    rd(12, 2, "wr_then_exl"); rd(14, 32'h90, "wr_epc");
    rst = 1; #1;
    chk("rst_settle_flush", {31'h0, flush}, 0);
    rd(12, 0, "rst_settle_status"); rd(14, 0, "rst_settle_epc"); rd(13, 0, "rst_settle_cause");
    step();
    rst = 0;
    ex_valid = 1; ex_ov = 1; ex_pc = 32'hA0; #1;
    chk("post_rst_flush", {31'h0, flush}, 1);
    step(); idle(); rd(14, 32'hA0, "post_rst_epc");
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
